// File: rtl/lsu_master.sv
// Load/store unit: CPU-side initiator for the byte-addressed data memory.
// One request in flight; alignment/range checked before any memory access.
module lsu_master #(
  parameter int ADDR_W    = 11,
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_base,
  input  logic [15:0]       req_offset,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_fault,
  output logic              resp_is_load,
  output logic [15:0]       fault_count,
  output logic              mem_ena,
  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_ssignal,
  output logic [2:0]        mem_lsignal,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LH  = 3'b010;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  state_t      state;
  logic [2:0]  op;
  logic [31:0] ea;
  logic [31:0] wdata;

  logic [31:0] ea_next;
  logic        is_word;
  logic        is_half;
  logic [2:0]  size;
  logic [32:0] ea_end;
  logic        misaligned;
  logic        out_of_range;
  logic [1:0]  fault_next;
  logic        op_is_load;
  logic        req_is_load;

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign op_is_load  = (op <= OP_LHU);
  assign req_is_load = (req_op <= OP_LHU);

  // Effective address and fault classification of the incoming request
  always_comb begin
    ea_next = req_base + {{16{req_offset[15]}}, req_offset};
    is_word = (req_op == OP_LW) || (req_op == OP_SW);
    is_half = (req_op == OP_LH) || (req_op == OP_LHU) ||
              (req_op == OP_SH);
    size    = is_word ? 3'd4 : (is_half ? 3'd2 : 3'd1);
    // 33-bit sum so addresses near the top cannot wrap into range
    ea_end  = {1'b0, ea_next} + {30'd0, size};
    misaligned   = (is_word && (ea_next[1:0] != 2'b00)) ||
                   (is_half && ea_next[0]);
    out_of_range = (ea_end > 33'(MEM_BYTES));
    if (misaligned)        fault_next = 2'b01;
    else if (out_of_range) fault_next = 2'b10;
    else                   fault_next = 2'b00;
  end

  // Memory strobes decoded from state and registered request fields
  always_comb begin
    mem_ena     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_ssignal = 2'b11;
    mem_lsignal = 3'b111;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (state == ACCESS) begin
      mem_ena  = 1'b1;
      mem_addr = ea[ADDR_W-1:0];
      if (op_is_load) begin
        mem_read    = 1'b1;
        mem_lsignal = op;
      end else begin
        mem_write = 1'b1;
        mem_wdata = wdata;
        unique case (1'b1)
          (op == OP_SW): mem_ssignal = 2'b00;
          (op == OP_SB): mem_ssignal = 2'b01;
          default:       mem_ssignal = 2'b10;
        endcase
      end
    end
  end

  // Request/response FSM with registered response fields
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op           <= OP_LW;
      ea           <= '0;
      wdata        <= '0;
      resp_rdata   <= '0;
      resp_fault   <= 2'b00;
      resp_is_load <= 1'b0;
      fault_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op           <= req_op;
            ea           <= ea_next;
            wdata        <= req_wdata;
            resp_rdata   <= '0;
            resp_fault   <= fault_next;
            resp_is_load <= req_is_load;
            if (fault_next != 2'b00) begin
              state <= RESP;
              if (fault_count != 16'hFFFF)
                fault_count <= fault_count + 16'd1;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (op_is_load) begin
            unique case (1'b1)
              (op == OP_LB):
                resp_rdata <= {{24{mem_rdata[7]}}, mem_rdata[7:0]};
              (op == OP_LH):
                resp_rdata <= {{16{mem_rdata[15]}}, mem_rdata[15:0]};
              default:
                resp_rdata <= mem_rdata;
            endcase
          end
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_master.sv
// Scoreboard bench for lsu_master with a byte-array memory and
// a reference model working on plain byte arrays.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_base = '0;
  logic [15:0] req_offset = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic        resp_is_load;
  logic [15:0] fault_count;
  logic        mem_ena, mem_read, mem_write;
  logic [1:0]  mem_ssignal;
  logic [2:0]  mem_lsignal;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_master #(.ADDR_W(11), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .resp_is_load(resp_is_load), .fault_count(fault_count),
    .mem_ena(mem_ena), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ssignal(mem_ssignal), .mem_lsignal(mem_lsignal),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // ---------------- memory behind the port ----------------
  logic [7:0]  mem [1024];
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    mem_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (int'(mem_addr) + i < 1024)
        rd_word[8*i +: 8] = mem[int'(mem_addr) + i];
    if (mem_ena && mem_read) begin
      case (mem_lsignal)
        3'b000:          mem_rdata = rd_word;
        3'b001, 3'b011:  mem_rdata = {24'd0, rd_word[7:0]};
        3'b010, 3'b100:  mem_rdata = {16'd0, rd_word[15:0]};
        default:         mem_rdata = '0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (mem_ena && mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if ((mem_ssignal == 2'b00) ||
            (mem_ssignal == 2'b01 && i < 1) ||
            (mem_ssignal == 2'b10 && i < 2))
          if (int'(mem_addr) + i < 1024)
            mem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    logic        is_load;
    int          lat;
    int          acc;
    logic [2:0]  op;
    logic [31:0] ea;
    logic [31:0] wd;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ref_mem [1024];
  int          ref_faults = 0;

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [31:0] base,
                                 input logic [15:0] off,
                                 input logic [31:0] wd);
    exp_t e;
    longint unsigned last;
    int sz;
    logic [31:0] v;
    e.op = op;
    e.wd = wd;
    e.ea = base + {{16{off[15]}}, off};
    e.is_load = (op < 3'd5);
    e.rdata = '0;
    e.fault = 2'b00;
    e.acc = 0;
    if (op == 3'd0 || op == 3'd5)                   sz = 4;
    else if (op == 3'd2 || op == 3'd4 || op == 3'd7) sz = 2;
    else                                            sz = 1;
    last = longint'(e.ea) + sz;
    if ((e.ea % sz) != 0)  e.fault = 2'b01;
    else if (last > 1024)  e.fault = 2'b10;
    if (e.fault != 2'b00) begin
      if (ref_faults < 65535) ref_faults++;
      e.lat = 1;
    end else begin
      e.lat = 2;
      if (!e.is_load) begin
        for (int i = 0; i < sz; i++)
          ref_mem[e.ea + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++)
          v[8*i +: 8] = ref_mem[e.ea + i];
        if (op == 3'd1 && v[7])  v = v | 32'hFFFF_FF00;
        if (op == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  localparam logic [2:0] LW = 0, LB = 1, LH = 2, LBU = 3, LHU = 4;
  localparam logic [2:0] SW = 5, SB = 6, SH = 7;

  task automatic issue(input logic [2:0] op, input logic [31:0] base,
                       input logic [15:0] off, input logic [31:0] wd);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!req_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("issue_timeout", 64'(req_ready), 64'd1);
      return;
    end
    e = model(op, base, off, wd);
    req_valid  = 1'b1;
    req_op     = op;
    req_base   = base;
    req_offset = off;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e.acc = cyc;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || !req_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_valid = 1'b0;
  exp_t got;

  always @(negedge clk) begin
    if (!rst) begin
      if (req_ready)
        chk("idle_mem_outputs",
            {mem_ena, mem_read, mem_write, mem_ssignal, mem_lsignal,
             mem_addr, mem_wdata},
            {1'b0, 1'b0, 1'b0, 2'b11, 3'b111, 11'd0, 32'd0});
      if (sbq.size() != 0 && cyc == sbq[0].acc) begin
        chk("mem_ena", 64'(mem_ena), 64'(sbq[0].fault == 2'b00));
        if (sbq[0].fault == 2'b00) begin
          chk("mem_addr", 64'(mem_addr), 64'(sbq[0].ea[10:0]));
          if (sbq[0].is_load) begin
            chk("load_strobes",
                {mem_read, mem_write, mem_ssignal, mem_lsignal},
                {1'b1, 1'b0, 2'b11, sbq[0].op});
          end else begin
            chk("store_strobes",
                {mem_read, mem_write, mem_ssignal, mem_lsignal},
                {1'b0, 1'b1,
                 (sbq[0].op == SW) ? 2'b00 :
                 (sbq[0].op == SB) ? 2'b01 : 2'b10, 3'b111});
            chk("mem_wdata", 64'(mem_wdata), 64'(sbq[0].wd));
          end
        end
      end
      if (resp_valid && !prev_valid) begin
        if (sbq.size() == 0)
          chk("unexpected_resp", 64'd1, 64'd0);
        else
          chk("latency", 64'(cyc - sbq[0].acc + 1), 64'(sbq[0].lat));
      end
      if (resp_valid && resp_ready && sbq.size() != 0) begin
        got = sbq.pop_front();
        chk("resp_rdata", 64'(resp_rdata), 64'(got.rdata));
        chk("resp_fault", 64'(resp_fault), 64'(got.fault));
        chk("resp_is_load", 64'(resp_is_load), 64'(got.is_load));
      end
    end
    prev_valid <= resp_valid;
  end

  // random backpressure, enabled only in the random phase
  bit rnd_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [31:0] held_rdata;
  logic [1:0]  held_fault;
  int          t;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp", {resp_valid, resp_rdata, resp_fault, resp_is_load},
        {1'b0, 32'd0, 2'b00, 1'b0});
    chk("rst_fault_count", 64'(fault_count), 64'd0);

    // word round trip
    issue(SW, 32'h10, 16'h0, 32'hDEADBEEF);
    issue(LW, 32'h10, 16'h0, 32'h0);
    // sign/zero extension
    issue(SB, 32'h20, 16'h0, 32'h1234_5680);
    issue(LB, 32'h20, 16'h0, 32'h0);
    issue(LBU, 32'h20, 16'h0, 32'h0);
    issue(SH, 32'h22, 16'h0, 32'hABCD_8001);
    issue(LH, 32'h22, 16'h0, 32'h0);
    issue(LHU, 32'h22, 16'h0, 32'h0);
    // negative offset
    issue(SW, 32'h104, 16'hFFFC, 32'h12345678);
    issue(LW, 32'h100, 16'h0, 32'h0);
    // faults and boundaries
    issue(LW, 32'h102, 16'h0, 32'h0);
    issue(LH, 32'h3FF, 16'h0, 32'h0);
    issue(SW, 32'h3FC, 16'h0, 32'hCAFEF00D);
    issue(SW, 32'h3FD, 16'h0, 32'h0);
    issue(LB, 32'h400, 16'h0, 32'h0);
    issue(LB, 32'hFFFFFFFF, 16'h0, 32'h0);
    issue(LW, 32'h3FC, 16'h0, 32'h0);
    drain();
    chk("fault_count_5", 64'(fault_count), 64'd5);

    // backpressure
    resp_ready = 1'b0;
    issue(LW, 32'h10, 16'h0, 32'h0);
    t = 0;
    while (!resp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_rise", 64'(resp_valid), 64'd1);
    held_rdata = resp_rdata;
    held_fault = resp_fault;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {resp_valid, req_ready, resp_rdata, resp_fault},
          {1'b1, 1'b0, held_rdata, held_fault});
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    issue(LHU, 32'h10, 16'h0, 32'h0);
    drain();

    // reset during a store's ACCESS cycle
    issue(SW, 32'h40, 16'h0, 32'hA5A5A5A5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_op", {req_ready, resp_valid}, {1'b1, 1'b0});
    sbq.delete();
    ref_faults = 0;
    rst = 1'b0;
    chk("rst_mid_fault_count", 64'(fault_count), 64'd0);
    issue(LW, 32'h40, 16'h0, 32'h0);
    drain();

    // randomized traffic with random backpressure
    rnd_ready = 1'b1;
    for (int n = 0; n < 250; n++) begin
      logic [31:0] base;
      logic [15:0] off;
      if ($urandom_range(0, 11) == 0) base = $urandom;
      else base = 32'($urandom_range(0, 1040));
      off = 16'($urandom_range(0, 31)) - 16'd16;
      issue(3'($urandom_range(0, 7)), base, off, $urandom);
    end
    rnd_ready = 1'b0;
    #1 resp_ready = 1'b1;
    drain();
    chk("final_fault_count", 64'(fault_count), 64'(ref_faults));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
